dbus_store_buffer: RTL and testbench

- Sits directly downstream of the Memory stage, between its dreq/dresp port and the data-side cache/bus bridge.
- Stores are posted: each is accepted in a single cycle, with addr_ok and data_ok both set, into a DEPTH-entry FIFO. The FIFO then drains to the bus in order, with at most one bus transaction outstanding.
- Loads are issued only when the FIFO is empty and the bus is idle. This guarantees load-after-store ordering without address compare.

---
 rtl/dbus_store_buffer_if.sv | 23 ++
 rtl/dbus_store_buffer.sv | 126 ++++++++++++
 tb/tb_dbus_store_buffer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_store_buffer_if.sv
// Data-bus request/response bundle between the Memory stage, the store buffer
// and the cache/bus bridge.
interface dbus_store_buffer_if;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  dbus_req_t  req;
  dbus_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/dbus_store_buffer.sv
// Posted-store FIFO between the Memory stage and the data bus; loads wait for
// the FIFO to drain so they always observe earlier stores.
module dbus_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  dbus_store_buffer_if.slave   mem,
  dbus_store_buffer_if.master  bus,
  output logic                 empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, S_ADDR, S_DATA, L_ADDR, L_DATA, L_DROP} state_t;

  state_t        state, state_nxt;
  logic [PW:0]   count;
  logic [PW-1:0] head, tail;
  logic [31:0]   q_addr   [DEPTH];
  logic [2:0]    q_size   [DEPTH];
  logic [3:0]    q_strobe [DEPTH];
  logic [31:0]   q_data   [DEPTH];
  logic [31:0]   ld_addr;
  logic [2:0]    ld_size;
  logic          is_store, is_load, in_load, push, pop, ld_ack, ld_latch;

  assign is_store = mem.req.valid && (mem.req.strobe != 4'h0);
  assign is_load  = mem.req.valid && (mem.req.strobe == 4'h0);
  assign in_load  = (state == L_ADDR) || (state == L_DATA) || (state == L_DROP);
  assign push     = is_store && (count < FULL) && !in_load;
  assign empty    = (count == '0) && (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count/head/tail.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail]   <= mem.req.addr;
      q_size[tail]   <= mem.req.size;
      q_strobe[tail] <= mem.req.strobe;
      q_data[tail]   <= mem.req.data;
    end
    if (ld_latch) begin
      ld_addr <= mem.req.addr;
      ld_size <= mem.req.size;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ld_ack    = 1'b0;
    ld_latch  = 1'b0;
    bus.req   = '0;
    case (state)
      IDLE: begin
        // A store being accepted this cycle goes straight out next cycle.
        if (count != '0 || push) state_nxt = S_ADDR;
        else if (is_load) begin
          ld_latch  = 1'b1;
          state_nxt = L_ADDR;
        end
      end
      S_ADDR: begin
        bus.req.valid  = 1'b1;
        bus.req.addr   = q_addr[head];
        bus.req.size   = q_size[head];
        bus.req.strobe = q_strobe[head];
        bus.req.data   = q_data[head];
        if (bus.resp.addr_ok) begin
          if (bus.resp.data_ok) begin
            pop       = 1'b1;
            state_nxt = IDLE;
          end else state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.resp.data_ok) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      L_ADDR: begin
        if (!mem.req.valid) state_nxt = IDLE;
        else begin
          bus.req.valid = 1'b1;
          bus.req.addr  = ld_addr;
          bus.req.size  = ld_size;
          if (bus.resp.addr_ok) begin
            if (bus.resp.data_ok) begin
              ld_ack    = 1'b1;
              state_nxt = IDLE;
            end else state_nxt = L_DATA;
          end
        end
      end
      L_DATA: begin
        if (bus.resp.data_ok) begin
          ld_ack    = mem.req.valid;
          state_nxt = IDLE;
        end else if (!mem.req.valid) state_nxt = L_DROP;
      end
      L_DROP: if (bus.resp.data_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem.resp.addr_ok = !reset && (push || ld_ack);
    mem.resp.data_ok = !reset && (push || ld_ack);
    mem.resp.data    = (!reset && ld_ack) ? bus.resp.data : 32'h0;
  end
endmodule

// File: tb/tb_dbus_store_buffer.sv
// Directed bench for the store buffer: store posting, fill/wrap, load ordering,
// split handshakes, flush and mid-operation reset.
module tb_dbus_store_buffer;
  logic clk = 1'b0;
  logic reset;
  logic empty;
  int   n_chk = 0;
  int   n_fail = 0;

  dbus_store_buffer_if mem ();
  dbus_store_buffer_if bus ();

  dbus_store_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .mem   (mem),
    .bus   (bus),
    .empty (empty)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic up_store(input logic [31:0] a, input logic [31:0] d);
    mem.req.valid  = 1'b1;
    mem.req.addr   = a;
    mem.req.size   = 3'd2;
    mem.req.strobe = 4'hF;
    mem.req.data   = d;
  endtask

  task automatic up_load(input logic [31:0] a);
    mem.req.valid  = 1'b1;
    mem.req.addr   = a;
    mem.req.size   = 3'd2;
    mem.req.strobe = 4'h0;
    mem.req.data   = 32'h0;
  endtask

  task automatic up_idle;
    mem.req = '0;
  endtask

  task automatic dn(input logic a, input logic d, input logic [31:0] data);
    bus.resp.addr_ok = a;
    bus.resp.data_ok = d;
    bus.resp.data    = data;
  endtask

  task automatic chk_ack(input string tag, input logic ok, input logic [31:0] data);
    chk({tag, ".addr_ok"}, 32'(mem.resp.addr_ok), 32'(ok));
    chk({tag, ".data_ok"}, 32'(mem.resp.data_ok), 32'(ok));
    chk({tag, ".data"}, mem.resp.data, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    up_idle();
    dn(1'b0, 1'b0, 32'h0);
    tick(); tick();
    #1;
    chk_ack("rst_ack", 1'b0, 32'h0);
    chk("rst_oreq_valid", 32'(bus.req.valid), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    tick();
    reset = 1'b0;

    // 1: single store, bus answers in one cycle
    up_store(32'h8000_0010, 32'h1234_5678);
    dn(1'b1, 1'b1, 32'h0);
    #1;
    chk_ack("t1_accept", 1'b1, 32'h0);
    chk("t1_oreq_idle", 32'(bus.req.valid), 32'h0);
    tick();
    up_idle();
    #1;
    chk("t1_oreq_valid", 32'(bus.req.valid), 32'h1);
    chk("t1_oreq_addr", bus.req.addr, 32'h8000_0010);
    chk("t1_oreq_data", bus.req.data, 32'h1234_5678);
    chk("t1_oreq_strobe", 32'(bus.req.strobe), 32'hF);
    chk("t1_busy", 32'(empty), 32'h0);
    tick();
    #1;
    chk("t1_empty", 32'(empty), 32'h1);

    // 2: fill to DEPTH with bus stalled, fifth store retries, drain wraps
    tick();
    dn(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      up_store(32'h200 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      #1;
      chk($sformatf("t2_fill%0d", i), 32'(mem.resp.addr_ok), 32'h1);
      tick();
    end
    up_store(32'h210, 32'hA000_0004);
    #1;
    chk("t2_full_stall", 32'(mem.resp.addr_ok), 32'h0);
    chk("t2_head_addr", bus.req.addr, 32'h200);
    tick();
    dn(1'b1, 1'b1, 32'h0);
    #1;
    chk("t2_pop_cycle_stall", 32'(mem.resp.addr_ok), 32'h0);
    chk("t2_first_drain", bus.req.data, 32'hA000_0000);
    tick();
    #1;
    chk("t2_fifth_acked", 32'(mem.resp.addr_ok), 32'h1);
    tick();
    up_idle();
    for (int i = 1; i < 5; i++) begin
      #1;
      chk($sformatf("t2_drain%0d_valid", i), 32'(bus.req.valid), 32'h1);
      chk($sformatf("t2_drain%0d_addr", i), bus.req.addr, 32'h200 + 32'(4 * i));
      chk($sformatf("t2_drain%0d_data", i), bus.req.data, 32'hA000_0000 + 32'(i));
      tick();
      #1;
      chk($sformatf("t2_gap%0d", i), 32'(bus.req.valid), 32'h0);
      tick();
    end
    #1;
    chk("t2_empty", 32'(empty), 32'h1);

    // 3: load queued behind two stores
    dn(1'b0, 1'b0, 32'h0);
    up_store(32'h100, 32'h11);
    #1;
    chk("t3_st0_ack", 32'(mem.resp.addr_ok), 32'h1);
    tick();
    up_store(32'h104, 32'h22);
    #1;
    chk("t3_st1_ack", 32'(mem.resp.addr_ok), 32'h1);
    tick();
    up_load(32'h104);
    dn(1'b1, 1'b0, 32'h0);
    #1;
    chk("t3_oreq_st0", bus.req.addr, 32'h100);
    chk("t3_ld_wait0", 32'(mem.resp.addr_ok), 32'h0);
    tick();
    dn(1'b0, 1'b1, 32'h0);
    #1;
    chk("t3_sdata_novalid", 32'(bus.req.valid), 32'h0);
    chk("t3_ld_wait1", 32'(mem.resp.addr_ok), 32'h0);
    tick();
    dn(1'b1, 1'b1, 32'hDEAD_BEEF);
    #1;
    chk("t3_idle_gap", 32'(bus.req.valid), 32'h0);
    tick();
    #1;
    chk("t3_oreq_st1", bus.req.addr, 32'h104);
    chk("t3_oreq_st1_strobe", 32'(bus.req.strobe), 32'hF);
    chk("t3_ld_wait2", 32'(mem.resp.addr_ok), 32'h0);
    tick();
    #1;
    chk("t3_ld_latch_novalid", 32'(bus.req.valid), 32'h0);
    tick();
    #1;
    chk("t3_ld_oreq_addr", bus.req.addr, 32'h104);
    chk("t3_ld_oreq_strobe", 32'(bus.req.strobe), 32'h0);
    chk_ack("t3_ld_ack", 1'b1, 32'hDEAD_BEEF);
    tick();
    up_idle();
    dn(1'b0, 1'b0, 32'h0);
    #1;
    chk("t3_empty", 32'(empty), 32'h1);

    // 4: load with addr_ok at t, data_ok at t+3
    tick();
    up_load(32'h300);
    tick();
    dn(1'b1, 1'b0, 32'h0);
    #1;
    chk("t4_laddr_valid", 32'(bus.req.valid), 32'h1);
    chk("t4_laddr_addr", bus.req.addr, 32'h300);
    chk("t4_t_noack", 32'(mem.resp.addr_ok), 32'h0);
    for (int i = 1; i < 3; i++) begin
      tick();
      dn(1'b1, 1'b0, 32'h0);
      #1;
      chk($sformatf("t4_t%0d_novalid", i), 32'(bus.req.valid), 32'h0);
      chk($sformatf("t4_t%0d_noack", i), 32'(mem.resp.data_ok), 32'h0);
    end
    tick();
    dn(1'b0, 1'b1, 32'hCAFE_0004);
    #1;
    chk("t4_t3_novalid", 32'(bus.req.valid), 32'h0);
    chk_ack("t4_t3_ack", 1'b1, 32'hCAFE_0004);
    tick();
    up_idle();
    dn(1'b0, 1'b0, 32'h0);
    #1;
    chk("t4_empty", 32'(empty), 32'h1);

    // 5: load flushed after addr_ok; data is dropped, next store proceeds
    tick();
    up_load(32'h400);
    tick();
    dn(1'b1, 1'b0, 32'h0);
    #1;
    chk("t5_laddr_valid", 32'(bus.req.valid), 32'h1);
    tick();
    up_idle();
    dn(1'b0, 1'b0, 32'h0);
    #1;
    chk("t5_flush_noack", 32'(mem.resp.addr_ok), 32'h0);
    tick();
    dn(1'b0, 1'b1, 32'h55);
    #1;
    chk_ack("t5_drop_noack", 1'b0, 32'h0);
    chk("t5_drop_busy", 32'(empty), 32'h0);
    tick();
    dn(1'b0, 1'b0, 32'h0);
    up_store(32'h500, 32'h66);
    #1;
    chk("t5_idle_again", 32'(bus.req.valid), 32'h0);
    chk_ack("t5_store_ack", 1'b1, 32'h0);
    tick();
    up_idle();
    dn(1'b1, 1'b1, 32'h0);
    #1;
    chk("t5_store_oreq", bus.req.addr, 32'h500);
    tick();
    #1;
    chk("t5_empty", 32'(empty), 32'h1);

    // 6: reset with three stores buffered and a data phase pending
    dn(1'b0, 1'b0, 32'h0);
    up_store(32'h600, 32'h1);
    tick();
    up_store(32'h604, 32'h2);
    dn(1'b1, 1'b0, 32'h0);
    #1;
    chk("t6_saddr", bus.req.addr, 32'h600);
    tick();
    up_store(32'h608, 32'h3);
    dn(1'b0, 1'b0, 32'h0);
    #1;
    chk("t6_sdata_novalid", 32'(bus.req.valid), 32'h0);
    chk("t6_busy", 32'(empty), 32'h0);
    tick();
    up_idle();
    reset = 1'b1;
    #1;
    chk("t6_rst_noack", 32'(mem.resp.addr_ok), 32'h0);
    tick();
    reset = 1'b0;
    dn(1'b0, 1'b1, 32'h0);
    #1;
    chk("t6_post_empty", 32'(empty), 32'h1);
    chk("t6_post_novalid", 32'(bus.req.valid), 32'h0);
    tick();
    dn(1'b0, 1'b0, 32'h0);
    #1;
    chk("t6_stale_ignored_empty", 32'(empty), 32'h1);
    chk("t6_stale_ignored_valid", 32'(bus.req.valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
